// File: rtl/lsu_pkg.sv
// Shared types, memop encodings and the access-legality check for the LSU bus adapter.
package lsu_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_REQ,
    S_RESP,
    S_DONE,
    S_ERR
  } state_e;

  localparam logic [2:0] MEMOP_B  = 3'b000;
  localparam logic [2:0] MEMOP_H  = 3'b001;
  localparam logic [2:0] MEMOP_W  = 3'b010;
  localparam logic [2:0] MEMOP_BU = 3'b100;
  localparam logic [2:0] MEMOP_HU = 3'b101;

  // True for reserved memops, unsigned stores and misaligned halfword/word accesses.
  function automatic logic is_illegal(input logic [2:0] memop, input logic wen,
                                      input logic [1:0] lo);
    logic bad;
    bad = 1'b0;
    case (memop)
      MEMOP_B, MEMOP_BU: bad = 1'b0;
      MEMOP_H, MEMOP_HU: bad = lo[0];
      MEMOP_W:           bad = (lo != 2'b00);
      default:           bad = 1'b1;
    endcase
    if (wen && memop[2]) bad = 1'b1;
    return bad;
  endfunction

endpackage

// File: rtl/lsu_align.sv
// Byte-lane steering: store data replication with strobes, load extraction with extension.
module lsu_align
  import lsu_pkg::*;
(
  input  logic [1:0]  addr,
  input  logic [2:0]  memop,
  input  logic [31:0] wdata,
  input  logic [31:0] rdata,
  output logic [31:0] wdata_al,
  output logic [3:0]  wstrb,
  output logic [31:0] rdata_ext
);

  logic [31:0] shifted;

  always_comb begin
    wdata_al = wdata;
    wstrb    = 4'b1111;
    case (memop[1:0])
      2'b00: begin
        wdata_al = {4{wdata[7:0]}};
        wstrb    = 4'b0001 << addr;
      end
      2'b01: begin
        wdata_al = {2{wdata[15:0]}};
        wstrb    = 4'b0011 << {addr[1], 1'b0};
      end
      default: begin
        wdata_al = wdata;
        wstrb    = 4'b1111;
      end
    endcase
  end

  always_comb begin
    shifted = rdata >> {addr, 3'b000};
    case (memop)
      MEMOP_B:  rdata_ext = {{24{shifted[7]}}, shifted[7:0]};
      MEMOP_H:  rdata_ext = {{16{shifted[15]}}, shifted[15:0]};
      MEMOP_BU: rdata_ext = {24'h000000, shifted[7:0]};
      MEMOP_HU: rdata_ext = {16'h0000, shifted[15:0]};
      default:  rdata_ext = shifted;
    endcase
  end

endmodule

// File: rtl/lsu_bus_adapter.sv
// Core memory port to valid/ready bus adapter; one bus transaction per legal access.
// Optional response timeout enabled by defining LSU_TIMEOUT_EN.
module lsu_bus_adapter
  import lsu_pkg::*;
#(
  parameter int unsigned ADDR_W         = 32,
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              lsu_req,
  input  logic              lsu_wen,
  input  logic [2:0]        lsu_memop,
  input  logic [ADDR_W-1:0] lsu_addr,
  input  logic [31:0]       lsu_wdata,
  output logic [31:0]       lsu_rdata,
  output logic              lsu_busy,
  output logic              lsu_done,
  output logic              lsu_err,
  output logic              bus_req_valid,
  input  logic              bus_req_ready,
  output logic [ADDR_W-1:0] bus_req_addr,
  output logic              bus_req_wen,
  output logic [31:0]       bus_req_wdata,
  output logic [3:0]        bus_req_wstrb,
  input  logic              bus_resp_valid,
  output logic              bus_resp_ready,
  input  logic [31:0]       bus_resp_rdata,
  input  logic              bus_resp_err
);

  state_e            state_q, state_d;
  logic [ADDR_W-3:0] addr_hi_q;
  logic [1:0]        lo_q;
  logic              wen_q;
  logic [2:0]        memop_q;
  logic [31:0]       wdata_q;
  logic [3:0]        wstrb_q;
  logic [31:0]       rdata_q;
  logic              err_q;
  logic              latch_req;
  logic              resp_take;

  logic [1:0]  al_addr;
  logic [2:0]  al_memop;
  logic [31:0] al_wdata;
  logic [3:0]  al_wstrb;
  logic [31:0] al_rdata;

  // Aligner sees live core inputs while idle and the latched access afterwards.
  assign al_addr  = (state_q == S_IDLE) ? lsu_addr[1:0] : lo_q;
  assign al_memop = (state_q == S_IDLE) ? lsu_memop : memop_q;

  lsu_align u_align (
    .addr      (al_addr),
    .memop     (al_memop),
    .wdata     (lsu_wdata),
    .rdata     (bus_resp_rdata),
    .wdata_al  (al_wdata),
    .wstrb     (al_wstrb),
    .rdata_ext (al_rdata)
  );

`ifdef LSU_TIMEOUT_EN
  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [CNT_W-1:0] cnt_q;
  logic             tmo;

  // Counts RESP cycles without a response; held at zero outside RESP.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                      cnt_q <= '0;
    else if (state_q != S_RESP)    cnt_q <= '0;
    else if (!bus_resp_valid)      cnt_q <= cnt_q + CNT_W'(1);
  end
`else
  logic unused_timeout;
  assign unused_timeout = (TIMEOUT_CYCLES != 0);
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= S_IDLE;
    else      state_q <= state_d;
  end

  always_comb begin
    state_d   = state_q;
    latch_req = 1'b0;
    resp_take = 1'b0;
`ifdef LSU_TIMEOUT_EN
    tmo       = 1'b0;
`endif
    case (state_q)
      S_IDLE: begin
        if (lsu_req) begin
          if (is_illegal(lsu_memop, lsu_wen, lsu_addr[1:0])) begin
            state_d = S_ERR;
          end else begin
            state_d   = S_REQ;
            latch_req = 1'b1;
          end
        end
      end
      S_REQ: if (bus_req_ready) state_d = S_RESP;
      S_RESP: begin
        if (bus_resp_valid) begin
          state_d   = S_DONE;
          resp_take = 1'b1;
        end
`ifdef LSU_TIMEOUT_EN
        else if (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
          state_d = S_DONE;
          tmo     = 1'b1;
        end
`endif
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Access capture and response bookkeeping.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      addr_hi_q <= '0;
      lo_q      <= 2'b00;
      wen_q     <= 1'b0;
      memop_q   <= 3'b000;
      wdata_q   <= 32'h0;
      wstrb_q   <= 4'b0000;
      rdata_q   <= 32'h0;
      err_q     <= 1'b0;
    end else begin
      if (latch_req) begin
        addr_hi_q <= lsu_addr[ADDR_W-1:2];
        lo_q      <= lsu_addr[1:0];
        wen_q     <= lsu_wen;
        memop_q   <= lsu_memop;
        wdata_q   <= al_wdata;
        wstrb_q   <= lsu_wen ? al_wstrb : 4'b0000;
      end
      if (resp_take) begin
        err_q <= bus_resp_err;
        if (!wen_q && !bus_resp_err) rdata_q <= al_rdata;
      end
`ifdef LSU_TIMEOUT_EN
      if (tmo) err_q <= 1'b1;
`endif
    end
  end

  assign bus_req_valid  = (state_q == S_REQ);
  assign bus_resp_ready = (state_q == S_RESP);
  assign bus_req_addr   = {addr_hi_q, 2'b00};
  assign bus_req_wen    = wen_q;
  assign bus_req_wdata  = wdata_q;
  assign bus_req_wstrb  = wstrb_q;
  assign lsu_rdata      = rdata_q;
  assign lsu_done       = (state_q == S_DONE) || (state_q == S_ERR);
  assign lsu_err        = (state_q == S_ERR) || ((state_q == S_DONE) && err_q);
  // Busy is forced low during reset so a held lsu_req cannot stall the core.
  assign lsu_busy       = rst && (((state_q == S_IDLE) && lsu_req) || (state_q == S_REQ) ||
                                  (state_q == S_RESP) || (state_q == S_ERR));

endmodule

// File: tb/tb_lsu_bus_adapter.sv
// Directed self-checking bench for lsu_bus_adapter (timeout case only when LSU_TIMEOUT_EN is defined).
module tb_lsu_bus_adapter;

  localparam int unsigned ADDR_W = 32;

  logic              clk;
  logic              rst;
  logic              lsu_req;
  logic              lsu_wen;
  logic [2:0]        lsu_memop;
  logic [ADDR_W-1:0] lsu_addr;
  logic [31:0]       lsu_wdata;
  logic [31:0]       lsu_rdata;
  logic              lsu_busy;
  logic              lsu_done;
  logic              lsu_err;
  logic              bus_req_valid;
  logic              bus_req_ready;
  logic [ADDR_W-1:0] bus_req_addr;
  logic              bus_req_wen;
  logic [31:0]       bus_req_wdata;
  logic [3:0]        bus_req_wstrb;
  logic              bus_resp_valid;
  logic              bus_resp_ready;
  logic [31:0]       bus_resp_rdata;
  logic              bus_resp_err;

  int errors = 0;
  int checks = 0;

  lsu_bus_adapter #(.ADDR_W(ADDR_W), .TIMEOUT_CYCLES(8)) dut (
    .clk            (clk),
    .rst            (rst),
    .lsu_req        (lsu_req),
    .lsu_wen        (lsu_wen),
    .lsu_memop      (lsu_memop),
    .lsu_addr       (lsu_addr),
    .lsu_wdata      (lsu_wdata),
    .lsu_rdata      (lsu_rdata),
    .lsu_busy       (lsu_busy),
    .lsu_done       (lsu_done),
    .lsu_err        (lsu_err),
    .bus_req_valid  (bus_req_valid),
    .bus_req_ready  (bus_req_ready),
    .bus_req_addr   (bus_req_addr),
    .bus_req_wen    (bus_req_wen),
    .bus_req_wdata  (bus_req_wdata),
    .bus_req_wstrb  (bus_req_wstrb),
    .bus_resp_valid (bus_resp_valid),
    .bus_resp_ready (bus_resp_ready),
    .bus_resp_rdata (bus_resp_rdata),
    .bus_resp_err   (bus_resp_err)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic start(input logic wen, input logic [2:0] memop, input logic [31:0] addr,
                       input logic [31:0] wdata);
    lsu_req   = 1'b1;
    lsu_wen   = wen;
    lsu_memop = memop;
    lsu_addr  = addr;
    lsu_wdata = wdata;
  endtask

  task automatic bus(input logic ready, input logic valid, input logic [31:0] rdata,
                     input logic err);
    bus_req_ready  = ready;
    bus_resp_valid = valid;
    bus_resp_rdata = rdata;
    bus_resp_err   = err;
  endtask

  task automatic finish_access();
    lsu_req = 1'b0;
    bus(1'b0, 1'b0, 32'h0, 1'b0);
    tick();
  endtask

  initial begin
    rst = 1'b1;
    lsu_req = 1'b0; lsu_wen = 1'b0; lsu_memop = 3'b000; lsu_addr = '0; lsu_wdata = '0;
    bus(1'b0, 1'b0, 32'h0, 1'b0);
    #2 rst = 1'b0;
    #2;
    chk("rst_req_valid", bus_req_valid, 0);
    chk("rst_resp_ready", bus_resp_ready, 0);
    chk("rst_busy", lsu_busy, 0);
    chk("rst_done", lsu_done, 0);
    chk("rst_rdata", lsu_rdata, 32'h0);
    tick(); tick();
    rst = 1'b1;

    // LB at 0x8000_0003, zero-wait bus
    bus(1'b1, 1'b1, 32'h80AA_BBCC, 1'b0);
    start(1'b0, 3'b000, 32'h8000_0003, 32'h0);
    #1 chk("lb_busy_idle", lsu_busy, 1);
    tick();
    chk("lb_req_valid", bus_req_valid, 1);
    chk("lb_req_addr", bus_req_addr, 32'h8000_0000);
    chk("lb_wstrb", {28'h0, bus_req_wstrb}, 32'h0);
    chk("lb_wen", bus_req_wen, 0);
    chk("lb_done_c1", lsu_done, 0);
    tick();
    chk("lb_resp_ready", bus_resp_ready, 1);
    chk("lb_req_valid_off", bus_req_valid, 0);
    chk("lb_done_c2", lsu_done, 0);
    tick();
    chk("lb_done_c3", lsu_done, 1);
    chk("lb_err", lsu_err, 0);
    chk("lb_busy_done", lsu_busy, 0);
    chk("lb_rdata", lsu_rdata, 32'hFFFF_FF80);
    finish_access();
    chk("lb_done_clear", lsu_done, 0);

    // SH at 0x1002
    bus(1'b1, 1'b1, 32'hFFFF_FFFF, 1'b0);
    start(1'b1, 3'b001, 32'h0000_1002, 32'h1234_5678);
    tick();
    chk("sh_req_addr", bus_req_addr, 32'h0000_1000);
    chk("sh_wdata", bus_req_wdata, 32'h5678_5678);
    chk("sh_wstrb", {28'h0, bus_req_wstrb}, 32'hC);
    chk("sh_wen", bus_req_wen, 1);
    chk("sh_busy_req", lsu_busy, 1);
    tick();
    chk("sh_busy_resp", lsu_busy, 1);
    tick();
    chk("sh_done", lsu_done, 1);
    chk("sh_busy_done", lsu_busy, 0);
    chk("sh_err", lsu_err, 0);
    chk("sh_rdata_kept", lsu_rdata, 32'hFFFF_FF80);
    finish_access();

    // LW at 0x1001 is misaligned
    bus(1'b1, 1'b1, 32'h0, 1'b0);
    start(1'b0, 3'b010, 32'h0000_1001, 32'h0);
    tick();
    chk("lwmis_req_valid", bus_req_valid, 0);
    chk("lwmis_done", lsu_done, 1);
    chk("lwmis_err", lsu_err, 1);
    chk("lwmis_rdata", lsu_rdata, 32'hFFFF_FF80);
    finish_access();
    chk("lwmis_req_valid_after", bus_req_valid, 0);

    // Reserved memop 011 and unsigned store both error
    start(1'b0, 3'b011, 32'h0, 32'h0);
    tick();
    chk("memop011_err", lsu_err, 1);
    finish_access();
    start(1'b1, 3'b100, 32'h0, 32'h0);
    tick();
    chk("sbu_err", lsu_err, 1);
    chk("sbu_req_valid", bus_req_valid, 0);
    finish_access();

    // LHU at 0x2000 with ready held low 5 cycles and response 3 cycles late
    bus(1'b0, 1'b0, 32'h0, 1'b0);
    start(1'b0, 3'b101, 32'h0000_2000, 32'h0);
    tick();
    for (int i = 0; i < 5; i++) begin
      chk("lhu_req_valid_hold", bus_req_valid, 1);
      chk("lhu_addr_hold", bus_req_addr, 32'h0000_2000);
      chk("lhu_busy_req", lsu_busy, 1);
      tick();
    end
    bus_req_ready = 1'b1;
    chk("lhu_addr_accept", bus_req_addr, 32'h0000_2000);
    tick();
    bus_req_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk("lhu_resp_ready_wait", bus_resp_ready, 1);
      chk("lhu_busy_resp", lsu_busy, 1);
      tick();
    end
    bus(1'b0, 1'b1, 32'hDEAD_BEEF, 1'b0);
    tick();
    chk("lhu_done", lsu_done, 1);
    chk("lhu_busy_done", lsu_busy, 0);
    chk("lhu_rdata", lsu_rdata, 32'h0000_BEEF);
    finish_access();

    // LH at offset 2 sign-extends the upper half
    bus(1'b1, 1'b1, 32'h8001_1234, 1'b0);
    start(1'b0, 3'b001, 32'h0000_0002, 32'h0);
    tick(); tick(); tick();
    chk("lh_rdata", lsu_rdata, 32'hFFFF_8001);
    finish_access();

    // LBU at offset 1 zero-extends
    bus(1'b1, 1'b1, 32'h0000_F200, 1'b0);
    start(1'b0, 3'b100, 32'h0000_0001, 32'h0);
    tick(); tick(); tick();
    chk("lbu_rdata", lsu_rdata, 32'h0000_00F2);
    finish_access();

    // SB at 0x5 replicates the byte into every lane, strobe on lane 1
    bus(1'b1, 1'b1, 32'h0, 1'b0);
    start(1'b1, 3'b000, 32'h0000_0005, 32'h0000_00AB);
    tick();
    chk("sb_addr", bus_req_addr, 32'h0000_0004);
    chk("sb_wdata", bus_req_wdata, 32'hABAB_ABAB);
    chk("sb_wstrb", {28'h0, bus_req_wstrb}, 32'h2);
    tick(); tick();
    chk("sb_done", lsu_done, 1);
    finish_access();

    // Bus error on a load keeps the previous result
    bus(1'b1, 1'b1, 32'h1111_1111, 1'b1);
    start(1'b0, 3'b010, 32'h0000_0000, 32'h0);
    tick(); tick(); tick();
    chk("buserr_done", lsu_done, 1);
    chk("buserr_err", lsu_err, 1);
    chk("buserr_rdata", lsu_rdata, 32'h0000_00F2);
    finish_access();

    // Reset asserted while waiting for the response
    bus(1'b1, 1'b0, 32'h0, 1'b0);
    start(1'b0, 3'b010, 32'h0000_3000, 32'h0);
    tick(); tick();
    chk("rr_resp_ready_pre", bus_resp_ready, 1);
    rst = 1'b0;
    #1;
    chk("rr_req_valid", bus_req_valid, 0);
    chk("rr_resp_ready", bus_resp_ready, 0);
    chk("rr_busy", lsu_busy, 0);
    chk("rr_rdata", lsu_rdata, 32'h0);
    lsu_req = 1'b0;
    tick();
    rst = 1'b1;
    bus(1'b0, 1'b1, 32'h5555_5555, 1'b0);
    tick();
    chk("rr_late_resp_ready", bus_resp_ready, 0);
    chk("rr_late_done", lsu_done, 0);
    chk("rr_late_rdata", lsu_rdata, 32'h0);
    bus(1'b1, 1'b1, 32'hCAFE_F00D, 1'b0);
    start(1'b0, 3'b010, 32'h0000_3004, 32'h0);
    tick(); tick(); tick();
    chk("rr_next_done", lsu_done, 1);
    chk("rr_next_rdata", lsu_rdata, 32'hCAFE_F00D);
    finish_access();

`ifdef LSU_TIMEOUT_EN
    // Response never arrives: error after 8 RESP cycles
    bus(1'b1, 1'b0, 32'h0, 1'b0);
    start(1'b0, 3'b010, 32'h0000_0040, 32'h0);
    tick(); tick();
    bus_req_ready = 1'b0;
    for (int i = 0; i < 7; i++) begin
      tick();
      chk("tmo_waiting", lsu_done, 0);
    end
    tick();
    chk("tmo_done", lsu_done, 1);
    chk("tmo_err", lsu_err, 1);
    chk("tmo_rdata", lsu_rdata, 32'hCAFE_F00D);
    finish_access();
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/lsu_bus_adapter.md
Name: lsu_bus_adapter

Overview:
- Load/store unit directly downstream of the single-cycle RV32 core's memory port.
- Consumes the core's memop, address, store data and write enable, and issues one valid/ready bus transaction per access.
  - Bus address is word-aligned; store data is lane-replicated with byte strobes.
- Returns aligned, sign/zero-extended load data and stalls the core through `lsu_busy` until the access completes.

Parameters:
- ADDR_W, 32, core and bus address width
- TIMEOUT_CYCLES, 255, response-wait limit; used only with LSU_TIMEOUT_EN

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous active-low reset
- lsu_req  in  1  core has a load/store this cycle; held stable while lsu_busy
- lsu_wen  in  1  1=store, 0=load
- lsu_memop  in  3  RV funct3: 000 B, 001 H, 010 W, 100 BU, 101 HU
- lsu_addr  in  ADDR_W  byte address
- lsu_wdata  in  32  store data (rs2)
- lsu_rdata  out  32  extended load result
- lsu_busy  out  1  stall core
- lsu_done  out  1  one-cycle completion pulse
- lsu_err  out  1  valid with lsu_done: misaligned, illegal memop, bus error or timeout
- bus_req_valid  out  1  request valid
- bus_req_ready  in  1  request accepted
- bus_req_addr  out  ADDR_W  {lsu_addr[ADDR_W-1:2], 2'b00}
- bus_req_wen  out  1  write request
- bus_req_wdata  out  32  lane-replicated store data
- bus_req_wstrb  out  4  byte strobes; 0000 on reads
- bus_resp_valid  in  1  response valid
- bus_resp_ready  out  1  response accepted
- bus_resp_rdata  in  32  read word
- bus_resp_err  in  1  bus error

Behaviour:
- Reset (rst=0, asynchronous):
  - State goes to IDLE.
  - All outputs go to 0, including lsu_rdata=0.
  - An in-flight request is abandoned; a late response arriving in IDLE is ignored (bus_resp_ready=0).
- States: IDLE, REQ, RESP, DONE, ERR.
- IDLE:
  - If lsu_req is low, stay in IDLE.
  - If lsu_req is high and the access is illegal, go to ERR.
    - Illegal means: memop in {011, 110, 111}; store with memop[2]=1; H/HU with addr[0]=1; W with addr[1:0]!=0.
  - If lsu_req is high and the access is legal, latch addr, wen, memop, aligned wdata and wstrb, then go to REQ.
- REQ:
  - bus_req_valid=1; request fields come from the latched registers and stay stable until accepted.
  - On bus_req_ready, go to RESP.
- RESP:
  - bus_resp_ready=1.
  - On bus_resp_valid: for a load with no error, capture the extracted/extended data into lsu_rdata.
  - err register <= bus_resp_err; go to DONE.
  - Stores also wait for a response.
- DONE: lsu_done=1 for one cycle, then IDLE. lsu_req is not sampled in DONE.
- ERR: lsu_done=1 and lsu_err=1 for one cycle; no bus traffic; then IDLE.
- lsu_busy = (IDLE & lsu_req) | REQ | RESP | ERR.
  - lsu_busy is 0 in DONE, so the core commits exactly in the DONE cycle.
- Minimum latency is 3 cycles from the lsu_req edge to lsu_done (IDLE→REQ→RESP→DONE), with zero-wait ready/valid.
- Store alignment:
  - SB: wdata={4{b}}, wstrb=0001<<addr[1:0].
  - SH: wdata={2{h}}, wstrb=0011<<{addr[1],1'b0}.
  - SW: wdata=wdata, wstrb=1111.
- Load extraction:
  - word >> (addr[1:0]*8), then sign- or zero-extend per memop.
- lsu_rdata holds its value until the next successful load. An errored access leaves lsu_rdata unchanged.
- Simultaneous ready and resp_valid in the REQ cycle: resp_valid is not sampled until RESP.

Optional Feature:
- Macro: LSU_TIMEOUT_EN.
- Defined:
  - A counter clears on entry to RESP and increments each RESP cycle without bus_resp_valid.
  - When the count reaches TIMEOUT_CYCLES, go to DONE with err=1 and lsu_rdata unchanged.
  - The response is no longer awaited.
- Undefined: no counter; RESP waits indefinitely.

Decomposition:
- Package lsu_pkg:
  - State enum.
  - MEMOP_B/H/W/BU/HU constants.
  - Function for the illegal-access check.
- One combinational sub-module, lsu_align:
  - Inputs: addr[1:0], memop, wdata, rdata.
  - Outputs: aligned wdata, wstrb, extended rdata.
  - Shared by store and load paths; unit-testable standalone.

Test Plan:
- LB at addr 0x8000_0003, ready=1, resp rdata=0x80AA_BBCC → bus_req_addr=0x8000_0000, wstrb=0000, lsu_rdata=0xFFFF_FF80, lsu_done on cycle 3, err=0.
- SH at 0x1002, wdata=0x1234_5678 → bus_req_wdata=0x5678_5678, wstrb=1100, wen=1; done after response, busy low only in DONE.
- LW at 0x1001 → no bus_req_valid ever; lsu_done=lsu_err=1 on cycle 1; lsu_rdata unchanged.
- LHU at 0x2000 with bus_req_ready held low 5 cycles and resp_valid delayed 3 cycles → request fields stable throughout, lsu_rdata=0x0000_BEEF for rdata 0xDEAD_BEEF, busy high until DONE.
- rst pulled low while in RESP → bus_req_valid/bus_resp_ready/lsu_busy drop immediately; a late resp_valid after release is ignored; next LW completes normally.
- LSU_TIMEOUT_EN with TIMEOUT_CYCLES=8: load with resp_valid never asserted → lsu_done with err=1 exactly 8 RESP cycles after entry.
